// File: rtl/mrd_tx_pkg.sv
// mrd_tx_pkg: shared types and widths for the mrd_sink_tx frame transmitter
package mrd_tx_pkg;
  localparam int DEPTH_DEF = 2048;
  localparam int PTS_W = 12;
  localparam int ADDR_W = $clog2(DEPTH_DEF);
  typedef enum logic [1:0] {IDLE, WAIT, SEND, GAP} state_t;
  typedef struct packed {
    logic [PTS_W-1:0] dftpts;
    logic [5:0] size;
    logic inverse;
  } cmd_t;
endpackage

// File: rtl/mrd_tx_ram.sv
// mrd_tx_ram: simple dual-port sample buffer, one write port and one registered read port
module mrd_tx_ram
  import mrd_tx_pkg::*;
#(
  parameter int W = 36,
  parameter int AW = ADDR_W
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0] wd,
  input  logic re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0] q
);
  logic [W-1:0] mem [1<<AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/mrd_sink_tx.sv
// mrd_sink_tx: buffers upstream samples and sends each commanded frame to the DFT sink as one sop..eop burst.
// Define MRD_TX_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_cnt is tied to 0.
module mrd_sink_tx
  import mrd_tx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW = 18,
  parameter int GAP_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [PTS_W-1:0] cmd_dftpts,
  input  logic [5:0] cmd_size,
  input  logic cmd_inverse,
  input  logic dft_sink_ready,
  output logic dft_sink_valid,
  output logic dft_sink_sop,
  output logic dft_sink_eop,
  output logic [DW-1:0] dft_sink_real,
  output logic [DW-1:0] dft_sink_imag,
  output logic [5:0] dft_size,
  output logic dft_inverse,
  output logic cmd_err,
  output logic [15:0] frame_cnt
);
  localparam int AW = $clog2(DEPTH);
  state_t state, nxt;
  cmd_t cmd;
  logic run, wr_en, rd_en, acc, legal, start, last;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [PTS_W-1:0] cnt;
  logic [2*DW-1:0] q;
  // run keeps the handshakes low while reset is held and for the first cycle after it
  assign in_ready = run && 32'(count) != DEPTH;
  assign wr_en = in_valid && in_ready;
  assign acc = cmd_valid && cmd_ready;
  assign legal = cmd_dftpts != '0 && 32'(cmd_dftpts) <= DEPTH;
  assign start = 32'(count) >= 32'(cmd.dftpts) && dft_sink_ready;
  assign last = cnt == cmd.dftpts - PTS_W'(1);
  assign dft_sink_real = dft_sink_valid ? q[2*DW-1:DW] : '0;
  assign dft_sink_imag = dft_sink_valid ? q[DW-1:0] : '0;
  assign dft_size = cmd.size;
  assign dft_inverse = cmd.inverse;
  mrd_tx_ram #(.W(2*DW), .AW(AW)) ram (
    .clk(clk),
    .we(wr_en),
    .wa(wr_ptr),
    .wd({in_real, in_imag}),
    .re(rd_en),
    .ra(rd_ptr),
    .q(q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = acc && legal ? WAIT : IDLE;
      WAIT: nxt = start ? SEND : WAIT;
      SEND: nxt = last ? GAP : SEND;
      GAP: nxt = cnt == PTS_W'(GAP_CYC - 1) ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = run && state == IDLE;
    rd_en = state == SEND;
  end
  // cnt restarts on every state change: read index in SEND, idle cycles in GAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cnt <= '0;
      cmd <= '0;
      cmd_err <= 1'b0;
      dft_sink_valid <= 1'b0;
      dft_sink_sop <= 1'b0;
      dft_sink_eop <= 1'b0;
    end else begin
      run <= 1'b1;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      cnt <= state != nxt ? '0 : cnt + PTS_W'(1);
      if (acc && legal) cmd <= {cmd_dftpts, cmd_size, cmd_inverse};
      cmd_err <= acc && !legal;
      dft_sink_valid <= rd_en;
      dft_sink_sop <= rd_en && cnt == '0;
      dft_sink_eop <= rd_en && last;
    end
  end
`ifdef MRD_TX_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt <= '0;
    else if (dft_sink_eop && dft_sink_valid) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_mrd_sink_tx.sv
// tb_mrd_sink_tx: randomized scoreboard bench for mrd_sink_tx against a queue-based frame model
module tb_mrd_sink_tx;
  localparam int DEPTH = 2048, DW = 18, GAP_CYC = 4;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready;
  logic [DW-1:0] in_real = '0, in_imag = '0;
  logic cmd_valid = 0, cmd_ready;
  logic [11:0] cmd_dftpts = '0;
  logic [5:0] cmd_size = '0;
  logic cmd_inverse = 0;
  logic dft_sink_ready = 1;
  logic dft_sink_valid, dft_sink_sop, dft_sink_eop;
  logic [DW-1:0] dft_sink_real, dft_sink_imag;
  logic [5:0] dft_size;
  logic dft_inverse, cmd_err;
  logic [15:0] frame_cnt;
  typedef struct {int pts; logic [5:0] size; logic inv;} fcmd_t;
  logic [2*DW-1:0] model_q[$];
  fcmd_t pend_q[$];
  logic [44:0] exp_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, n_out = 0, frames = 0;
  int first_cyc = 0, eop_cyc = 0, last_acc = 0, cmd_edge = 0;
  bit in_frame = 0;

  mrd_sink_tx #(.DEPTH(DEPTH), .DW(DW), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dftpts(cmd_dftpts),
    .cmd_size(cmd_size), .cmd_inverse(cmd_inverse),
    .dft_sink_ready(dft_sink_ready), .dft_sink_valid(dft_sink_valid),
    .dft_sink_sop(dft_sink_sop), .dft_sink_eop(dft_sink_eop),
    .dft_sink_real(dft_sink_real), .dft_sink_imag(dft_sink_imag),
    .dft_size(dft_size), .dft_inverse(dft_inverse),
    .cmd_err(cmd_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [127:0] got, logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endfunction

  // frames leave in write order, so a pending command claims the oldest buffered samples
  function automatic void resolve();
    while (pend_q.size() > 0 && model_q.size() >= pend_q[0].pts) begin
      fcmd_t c;
      logic [2*DW-1:0] d;
      c = pend_q.pop_front();
      for (int k = 0; k < c.pts; k++) begin
        d = model_q.pop_front();
        exp_q.push_back({d, k == 0, k == c.pts - 1, c.size, c.inv});
      end
    end
  endfunction

  task automatic write_samples(input int n, input bit ramp);
    int k = 0, b = 0;
    while (k < n && b < 20000) begin
      @(negedge clk);
      in_valid = 1;
      in_real = ramp ? DW'(k) : DW'($urandom);
      in_imag = ramp ? DW'(-k) : DW'($urandom);
      if (in_ready) begin
        model_q.push_back({in_real, in_imag});
        last_acc = cyc + 1;
        k++;
        resolve();
      end
      b++;
    end
    check("write_budget", k, n);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic send_cmd(input int pts, input logic [5:0] sz, input logic inv);
    int b = 0;
    @(negedge clk);
    while (!cmd_ready && b < 20000) begin
      @(negedge clk);
      b++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1;
    cmd_dftpts = 12'(pts);
    cmd_size = sz;
    cmd_inverse = inv;
    cmd_edge = cyc + 1;
    if (pts >= 1 && pts <= DEPTH) begin
      pend_q.push_back('{pts, sz, inv});
      resolve();
    end
    @(negedge clk);
    cmd_valid = 0;
    if (pts < 1 || pts > DEPTH) begin
      check("cmd_err_pulse", cmd_err, 1);
      @(negedge clk);
      check("cmd_err_clear", cmd_err, 0);
      check("idle_after_err", cmd_ready, 1);
    end else check("no_cmd_err", cmd_err, 0);
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() > 0 || in_frame) && b < 10000) begin
      @(negedge clk);
      b++;
    end
    check("drain_timeout", b < 10000, 1);
  endtask

  task automatic gap_to_ready(output int d);
    int b = 0;
    while (!cmd_ready && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    d = cyc - eop_cyc;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) in_frame = 0;
    else begin
      if (in_frame) check("gap_free", dft_sink_valid, 1);
      if (dft_sink_valid) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_sample", exp_q.size(), 1);
        else check("sample", {dft_sink_real, dft_sink_imag, dft_sink_sop, dft_sink_eop, dft_size, dft_inverse}, exp_q.pop_front());
        if (dft_sink_sop) first_cyc = cyc;
        if (dft_sink_eop) begin
          eop_cyc = cyc;
          frames++;
        end
      end else check("idle_strobes", {dft_sink_sop, dft_sink_eop, dft_sink_real, dft_sink_imag}, 0);
      in_frame = dft_sink_valid && !dft_sink_eop;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, b, d, ready_edge, pts;
    logic [5:0] sz;
    logic inv;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, cmd_ready, dft_sink_valid, dft_sink_sop, dft_sink_eop, dft_sink_real, dft_sink_imag, dft_size, dft_inverse, cmd_err, frame_cnt}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    check("ready_after_reset", {in_ready, cmd_ready}, 2'b11);
    // ramp frame: latency from command and gap before the next command
    write_samples(12, 1);
    send_cmd(12, 6'd0, 1'b0);
    drain();
    check("start_latency", first_cyc - cmd_edge, 2);
    gap_to_ready(d);
    check("gap_to_ready", d, GAP_CYC);
    // command waits for the buffer to fill
    write_samples(20, 0);
    send_cmd(24, 6'd5, 1'b1);
    base = n_out;
    repeat (10) @(negedge clk);
    check("wait_holds", n_out - base, 0);
    write_samples(4, 0);
    drain();
    check("fill_start_latency", first_cyc - last_acc, 2);
    // core not ready: start held off, then ready dropped mid-burst
    dft_sink_ready = 0;
    write_samples(10, 0);
    send_cmd(10, 6'd9, 1'b0);
    base = n_out;
    repeat (8) @(negedge clk);
    check("ready_holdoff", n_out - base, 0);
    dft_sink_ready = 1;
    ready_edge = cyc + 1;
    b = 0;
    while (n_out == base && b < 50) begin
      @(negedge clk);
      b++;
    end
    dft_sink_ready = 0;
    drain();
    check("ready_start_latency", first_cyc - ready_edge, 1);
    dft_sink_ready = 1;
    // full buffer, extra writes ignored, count held by simultaneous write and read
    write_samples(DEPTH, 0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_count", dut.count, DEPTH);
    in_valid = 1;
    repeat (4) @(negedge clk);
    in_valid = 0;
    base = n_out;
    fork
      send_cmd(DEPTH, 6'd33, 1'b1);
      write_samples(100, 0);
      begin
        b = 0;
        while (n_out - base < 50 && b < 5000) begin
          @(negedge clk);
          b++;
        end
        check("count_hold", dut.count, DEPTH - 1);
      end
    join
    drain();
    // illegal lengths, then a one-sample frame
    base = n_out;
    send_cmd(0, 6'd1, 1'b0);
    send_cmd(DEPTH + 1, 6'd2, 1'b1);
    check("no_output_illegal", n_out - base, 0);
    send_cmd(1, 6'd7, 1'b1);
    drain();
    check("single_sop_eop", first_cyc, eop_cyc);
    send_cmd(99, 6'd11, 1'b0);
    drain();
    // reset in the middle of a frame
    write_samples(16, 0);
    send_cmd(16, 6'd4, 1'b1);
    base = n_out;
    b = 0;
    while (n_out - base < 5 && b < 100) begin
      @(negedge clk);
      b++;
    end
    rst = 1;
    #1;
    check("reset_midframe_outputs", {in_ready, cmd_ready, dft_sink_valid, dft_sink_sop, dft_sink_eop, dft_sink_real, dft_sink_imag, dft_size, dft_inverse, cmd_err, frame_cnt}, 0);
    check("reset_count", dut.count, 0);
    exp_q.delete();
    model_q.delete();
    pend_q.delete();
    frames = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    // random frames after reset
    for (int i = 0; i < 8; i++) begin
      pts = $urandom_range(1, 40);
      sz = 6'($urandom);
      inv = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        write_samples(pts, 0);
        send_cmd(pts, sz, inv);
      end else fork
        send_cmd(pts, sz, inv);
        write_samples(pts, 0);
      join
      drain();
    end
    repeat (2) @(negedge clk);
`ifdef MRD_TX_FRAME_CNT_EN
    check("frame_cnt", frame_cnt, frames);
`else
    check("frame_cnt_tied", frame_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mrd_sink_tx.md
# mrd_sink_tx

Frame transmitter that drives the sink port of the mixed-radix DFT core. Upstream logic writes complex samples into an internal buffer and issues per-frame commands (point count, size index, inverse flag). The block emits each frame as one gap-free burst with sop/eop framing, starting only when the DFT core signals readiness and a whole frame is buffered. It sits between the sample source (CP removal / RE demapper) and the DFT core input.

## Interface
- DEPTH, 2048: sample buffer entries; power of two, ≥ largest DFT frame
- DW, 18: width of each real/imag component
- GAP_CYC, 4: minimum idle cycles after eop before the next command is accepted
- clk  in  1  clock
- rst  in  1  reset; one clock domain, reset is asynchronous and active-high
- in_valid  in  1  upstream sample valid
- in_ready  out  1  buffer can accept a sample
- in_real / in_imag  in  DW each  upstream sample
- cmd_valid  in  1  frame command valid
- cmd_ready  out  1  command accepted this cycle when both high
- cmd_dftpts  in  12  frame length in samples
- cmd_size  in  6  DFT size index passed to the core
- cmd_inverse  in  1  IDFT select passed to the core
- dft_sink_ready  in  1  DFT core ready for a new frame
- dft_sink_valid / dft_sink_sop / dft_sink_eop  out  1 each  frame strobes
- dft_sink_real / dft_sink_imag  out  DW each  sample to core
- dft_size  out  6  size index, held stable for the whole frame
- dft_inverse  out  1  inverse flag, held stable for the whole frame
- cmd_err  out  1  one-cycle pulse on an illegal command
- frame_cnt  out  16  frames sent (see Configuration)

## Operation
- Buffer: circular FIFO with a count register, range 0..DEPTH. Write on in_valid&in_ready. in_ready = (count != DEPTH), decoded combinationally from registers. A simultaneous write and read leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, SEND, GAP.
- IDLE: cmd_ready=1. On accept, latch dftpts/size/inverse. Legal dftpts is 1..DEPTH. An illegal value (0 or >DEPTH) is discarded, pulses cmd_err, and the FSM stays in IDLE. A legal value moves the FSM to WAIT.
- WAIT: start when count ≥ dftpts and dft_sink_ready=1, both evaluated in the same cycle. On start go to SEND.
- SEND: read one sample per cycle, dftpts reads total. dft_sink_ready is ignored after start, because the core drops ready while absorbing a frame. After the final read, go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE.
- Output strobes:
  - sop on the first sample of the frame.
  - eop on sample dftpts. When dftpts=1, sop and eop are high on the same cycle.
  - Valid is never deasserted inside a frame.
- dft_size/dft_inverse update at command latch, and only in IDLE.

## Timing
- Reset (async assert): all outputs 0, count 0, pointers 0, FSM IDLE, latched command cleared. Deassertion is taken synchronously. A frame in flight is truncated with no eop.
- Write-to-readable latency: 1 cycle.
- Start condition true in cycle t: the first sample (valid+sop) is registered out at t+2, made of a RAM read cycle plus an output register. Samples follow at t+2 … t+1+dftpts.
- The last read occurs at t+dftpts; GAP is entered at t+dftpts+1. The FSM returns to IDLE, and cmd_ready rises, GAP_CYC cycles after entering GAP.
- Data are output in exact write order. A sample written in the same cycle count reaches dftpts does not enable start until the next cycle.
- cmd_err pulses the cycle after the illegal command is accepted.

## Configuration
- MRD_TX_FRAME_CNT_EN defined: frame_cnt increments on each cycle with dft_sink_eop&dft_sink_valid. It wraps at 16'hFFFF→0 and resets to 0.
- Undefined: no counter logic is built and frame_cnt is tied to 0.

## Structure
- Package mrd_tx_pkg holds:
  - state enum
  - command struct (dftpts, size, inverse)
  - localparams for the dftpts width and the buffer address width (log2 DEPTH)
- Sub-module mrd_tx_ram: simple dual-port RAM, 1 write / 1 registered read port, width 2·DW, DEPTH deep.
- FIFO control and the FSM live in the top.

## Test plan
- Write 12 samples (real=k, imag=−k), command dftpts=12, size=0, ready=1 → 12 consecutive valids, sop on k=0, eop on k=11, dft_size=0 throughout. Next cmd_ready rises GAP_CYC=4 cycles after entering GAP.
- Command dftpts=24 with only 20 samples buffered → stays in WAIT, valid=0. Write 4 more → first sample emerges 2 cycles after the cycle count reaches 24.
- dft_sink_ready=0 while the frame is buffered, then raised → start is held off until ready. Dropping ready mid-frame does not interrupt the burst.
- Fill to DEPTH → in_ready=0, extra writes ignored. During SEND with constant in_valid, count holds at DEPTH−1 via simultaneous write and read.
- cmd_dftpts=0, then DEPTH+1 → cmd_err pulses each time, no output, FSM stays in IDLE. A following dftpts=1 → single cycle with sop=eop=1.
- Assert rst mid-frame at sample 5 → all outputs 0 immediately, count 0. A fresh frame after deassertion transmits correctly. With MRD_TX_FRAME_CNT_EN, frame_cnt counts only the frames that completed after reset.
